// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forwarding selects and divider FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        IDLE     = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

endpackage : hazard_pkg

// File: rtl/hazard_unit_fwd_sel.sv
// Operand-forwarding select for one execute-stage source register.
// Memory stage wins over writeback; register x0 never forwards.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output fwd_sel_t          sel
);

    logic hit_m_s;
    logic hit_w_s;

    assign hit_m_s = reg_write_m && (rd_m != {REG_AW{1'b0}}) && (rd_m == rs_e);
    assign hit_w_s = reg_write_w && (rd_w != {REG_AW{1'b0}}) && (rd_w == rs_e);

    // Priority select between the M and W bypass paths.
    always_comb begin
        sel = FWD_RF;
        if (hit_m_s) begin
            sel = FWD_M;
        end else if (hit_w_s) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule : fwd_sel

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, load-use/branch/divider
// stall and flush generation, divider-busy FSM and a saturating stall counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              mem_read_e,
    input  logic              pc_src_e,
    input  logic              div_en_e,
    input  logic              div_done_e,
    output logic [1:0]        fwd_rs1,
    output logic [1:0]        fwd_rs2,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              div_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    fwd_sel_t   fwd_rs1_s;
    fwd_sel_t   fwd_rs2_s;
    div_state_t state_q;
    div_state_t state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic       lu_s;
    logic       lu_eff_s;
    logic       dstall_s;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_e        (rs1_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .sel         (fwd_rs1_s)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_e        (rs2_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .sel         (fwd_rs2_s)
    );

    assign fwd_rs1 = fwd_rs1_s;
    assign fwd_rs2 = fwd_rs2_s;

    assign lu_s = mem_read_e && (rd_e != {REG_AW{1'b0}})
                  && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // Divider FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Divider FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (div_en_e && !div_done_e) begin
                    state_d = DIV_BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            DIV_BUSY: begin
                if (div_done_e) begin
                    state_d = IDLE;
                end else begin
                    state_d = DIV_BUSY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Hazard outputs; a divider stall outranks branch flushes so the divide is never killed.
    always_comb begin
        dstall_s = 1'b0;
        lu_eff_s = 1'b0;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        div_busy = 1'b0;
        case (state_q)
            IDLE: begin
                dstall_s = div_en_e && !div_done_e;
                div_busy = 1'b0;
            end
            DIV_BUSY: begin
                dstall_s = !div_done_e;
                div_busy = 1'b1;
            end
            default: begin
                dstall_s = 1'b0;
                div_busy = 1'b0;
            end
        endcase
        if (rst) begin
            dstall_s = 1'b0;
        end else begin
            lu_eff_s = lu_s && !pc_src_e && !dstall_s;
            stall_f  = dstall_s || lu_eff_s;
            stall_d  = dstall_s || lu_eff_s;
            stall_e  = dstall_s;
            flush_m  = dstall_s;
            flush_d  = !dstall_s && pc_src_e;
            flush_e  = !dstall_s && (pc_src_e || lu_eff_s);
        end
    end

    // Saturating stall-cycle counter next value.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule : hazard_unit

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: per-cycle expectations go through a
// scoreboard queue and are compared at the falling edge.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        reg_write_m, reg_write_w, mem_read_e, pc_src_e, div_en_e, div_done_e;
    logic [1:0]  fwd_rs1, fwd_rs2;
    logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, div_busy;
    logic [31:0] stall_cnt;

    typedef struct packed {
        logic [6:0]  ctl;
        logic [3:0]  fwd;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    // ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, div_busy}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_BUSY = 7'b0000001;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_BR   = 7'b0001100;
    localparam logic [6:0] C_DIV  = 7'b1110010;
    localparam logic [6:0] C_DIVB = 7'b1110011;

    hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .mem_read_e(mem_read_e), .pc_src_e(pc_src_e), .div_en_e(div_en_e),
        .div_done_e(div_done_e), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .div_busy(div_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] obs();
        return {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, div_busy, fwd_rs1, fwd_rs2};
    endfunction

    task automatic clear_inputs();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0;
        rd_m = 5'd0; rd_w = 5'd0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        mem_read_e = 1'b0; pc_src_e = 1'b0; div_en_e = 1'b0; div_done_e = 1'b0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wait(input logic [6:0] ctl, input logic [3:0] fwd, input int cnt);
        exp_t e;
        e.ctl = ctl; e.fwd = fwd; e.cnt = cnt;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic set_lu(input logic en);
        mem_read_e = en; rd_e = en ? 5'd7 : 5'd0; rs2_d = en ? 5'd7 : 5'd0;
    endtask

    task automatic test_reset();
        exp_t e;
        clear_inputs();
        rst = 1'b1; div_en_e = 1'b1; pc_src_e = 1'b1; set_lu(1'b1);
        rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        push_wait(C_NONE, {2'd2, 2'd0}, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== {e.ctl, e.fwd}) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected %b", obs(), {e.ctl, e.fwd});
        end
        n_checks++;
        if (stall_cnt !== e.cnt) begin
            n_fail++; $display("FAIL reset_cnt: got %0d expected %0d", stall_cnt, e.cnt);
        end
        next_cyc(); rst = 1'b0; clear_inputs();
    endtask

    task automatic test_forwarding();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            next_cyc();
            clear_inputs();
            case (i)
                0: begin rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1; rd_w = 5'd5; reg_write_w = 1'b1;
                         push_wait(C_NONE, {2'd2, 2'd0}, exp_cnt); end
                1: begin rs1_e = 5'd5; rd_m = 5'd5; rd_w = 5'd5; reg_write_w = 1'b1;
                         push_wait(C_NONE, {2'd1, 2'd0}, exp_cnt); end
                2: begin rs1_e = 5'd0; rd_m = 5'd0; reg_write_m = 1'b1; rd_w = 5'd0; reg_write_w = 1'b1;
                         push_wait(C_NONE, {2'd0, 2'd0}, exp_cnt); end
                3: begin rs1_e = 5'd3; rs2_e = 5'd9; rd_m = 5'd9; reg_write_m = 1'b1; rd_w = 5'd3; reg_write_w = 1'b1;
                         push_wait(C_NONE, {2'd1, 2'd2}, exp_cnt); end
                default: begin rs2_e = 5'd12; rd_m = 5'd11; reg_write_m = 1'b1; rd_w = 5'd12;
                         push_wait(C_NONE, {2'd0, 2'd0}, exp_cnt); end
            endcase
            e = sb.pop_front(); n_checks++;
            if (obs() !== {e.ctl, e.fwd}) begin
                n_fail++; $display("FAIL fwd_%0d: got %b expected %b", i, obs(), {e.ctl, e.fwd});
            end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            clear_inputs();
            if (i == 0) begin set_lu(1'b1); push_wait(C_LU, 4'd0, exp_cnt); end
            else if (i == 1) begin push_wait(C_NONE, 4'd0, exp_cnt + 1); end
            else begin mem_read_e = 1'b1; push_wait(C_NONE, 4'd0, exp_cnt + 1); end
            e = sb.pop_front(); n_checks++;
            if (obs() !== {e.ctl, e.fwd}) begin
                n_fail++; $display("FAIL load_use_%0d: got %b expected %b", i, obs(), {e.ctl, e.fwd});
            end
            n_checks++;
            if (stall_cnt !== e.cnt) begin
                n_fail++; $display("FAIL load_use_cnt_%0d: got %0d expected %0d", i, stall_cnt, e.cnt);
            end
        end
        exp_cnt = exp_cnt + 1;
    endtask

    task automatic test_branch_lu();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            next_cyc();
            clear_inputs();
            if (i == 0) begin set_lu(1'b1); pc_src_e = 1'b1; push_wait(C_BR, 4'd0, exp_cnt); end
            else begin push_wait(C_NONE, 4'd0, exp_cnt); end
            e = sb.pop_front(); n_checks++;
            if (obs() !== {e.ctl, e.fwd}) begin
                n_fail++; $display("FAIL branch_lu_%0d: got %b expected %b", i, obs(), {e.ctl, e.fwd});
            end
            n_checks++;
            if (stall_cnt !== e.cnt) begin
                n_fail++; $display("FAIL branch_lu_cnt_%0d: got %0d expected %0d", i, stall_cnt, e.cnt);
            end
        end
    endtask

    // Divide of 33-cycle latency, then release and one idle cycle.
    task automatic test_divide();
        exp_t e;
        for (int k = 1; k <= 35; k++) begin
            next_cyc();
            clear_inputs();
            div_en_e   = (k <= 34);
            div_done_e = (k == 34);
            if (k == 1) push_wait(C_DIV, 4'd0, exp_cnt);
            else if (k <= 33) push_wait(C_DIVB, 4'd0, exp_cnt + k - 1);
            else if (k == 34) push_wait(C_BUSY, 4'd0, exp_cnt + 33);
            else push_wait(C_NONE, 4'd0, exp_cnt + 33);
            e = sb.pop_front(); n_checks++;
            if (obs() !== {e.ctl, e.fwd}) begin
                n_fail++; $display("FAIL divide_%0d: got %b expected %b", k, obs(), {e.ctl, e.fwd});
            end
            n_checks++;
            if (stall_cnt !== e.cnt) begin
                n_fail++; $display("FAIL divide_cnt_%0d: got %0d expected %0d", k, stall_cnt, e.cnt);
            end
        end
        exp_cnt = exp_cnt + 33;
    endtask

    // Load-use (and a branch) during a divide: no flush_e/flush_d until the done cycle.
    task automatic test_div_lu();
        exp_t e;
        for (int k = 1; k <= 5; k++) begin
            next_cyc();
            clear_inputs();
            div_en_e = (k <= 4); div_done_e = (k == 4);
            set_lu(k <= 4);
            pc_src_e = (k == 2);
            if (k == 1) push_wait(C_DIV, 4'd0, exp_cnt);
            else if (k <= 3) push_wait(C_DIVB, 4'd0, exp_cnt + k - 1);
            else if (k == 4) push_wait(C_LU | C_BUSY, 4'd0, exp_cnt + 3);
            else push_wait(C_NONE, 4'd0, exp_cnt + 4);
            e = sb.pop_front(); n_checks++;
            if (obs() !== {e.ctl, e.fwd}) begin
                n_fail++; $display("FAIL div_lu_%0d: got %b expected %b", k, obs(), {e.ctl, e.fwd});
            end
            n_checks++;
            if (stall_cnt !== e.cnt) begin
                n_fail++; $display("FAIL div_lu_cnt_%0d: got %0d expected %0d", k, stall_cnt, e.cnt);
            end
        end
        exp_cnt = exp_cnt + 4;
    endtask

    // Zero-latency divide followed by two back-to-back 2-cycle divides.
    task automatic test_back_to_back();
        exp_t e;
        logic [6:0] ctl_tab [9];
        int         dcnt_tab [9];
        logic       en_tab [9];
        logic       done_tab [9];
        ctl_tab  = '{C_NONE, C_NONE, C_DIV, C_DIVB, C_BUSY, C_DIV, C_DIVB, C_BUSY, C_NONE};
        dcnt_tab = '{0, 0, 0, 1, 2, 2, 3, 4, 4};
        en_tab   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        done_tab = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 9; k++) begin
            next_cyc();
            clear_inputs();
            div_en_e = en_tab[k]; div_done_e = done_tab[k];
            push_wait(ctl_tab[k], 4'd0, exp_cnt + dcnt_tab[k]);
            e = sb.pop_front(); n_checks++;
            if (obs() !== {e.ctl, e.fwd}) begin
                n_fail++; $display("FAIL back_to_back_%0d: got %b expected %b", k, obs(), {e.ctl, e.fwd});
            end
            n_checks++;
            if (stall_cnt !== e.cnt) begin
                n_fail++; $display("FAIL back_to_back_cnt_%0d: got %0d expected %0d", k, stall_cnt, e.cnt);
            end
        end
        exp_cnt = exp_cnt + 4;
    endtask

    // Reset asserted in the 10th DIV_BUSY cycle with the divide still requested.
    task automatic test_reset_mid_div();
        exp_t e;
        for (int k = 1; k <= 12; k++) begin
            next_cyc();
            clear_inputs();
            div_en_e = (k <= 11);
            rst      = (k == 11);
            if (k == 1) push_wait(C_DIV, 4'd0, exp_cnt);
            else if (k <= 10) push_wait(C_DIVB, 4'd0, exp_cnt + k - 1);
            else if (k == 11) push_wait(C_BUSY, 4'd0, exp_cnt + 10);
            else push_wait(C_NONE, 4'd0, 0);
            e = sb.pop_front(); n_checks++;
            if (obs() !== {e.ctl, e.fwd}) begin
                n_fail++; $display("FAIL reset_mid_div_%0d: got %b expected %b", k, obs(), {e.ctl, e.fwd});
            end
            n_checks++;
            if (stall_cnt !== e.cnt) begin
                n_fail++; $display("FAIL reset_mid_div_cnt_%0d: got %0d expected %0d", k, stall_cnt, e.cnt);
            end
        end
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_lu();
        test_divide();
        test_div_lu();
        test_back_to_back();
        test_reset_mid_div();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_unit
